// File: rtl/instruction_phase_sequencer_pkg.sv
// instruction_phase_sequencer_pkg
//   Shared definitions for the instruction phase sequencer and the
//   JR/DJNZ-class decoders that consume its outputs.
//   - phase_e      : sub-phase encoding (PA, Pa, PR, P2)
//   - XPT_W        : width of the execution step counter
//   - ITABLE_RESET_DEF / XPT_MAX_DEF : default parameter values
package instruction_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_PA = 2'd0,
    PH_Pa = 2'd1,
    PH_PR = 2'd2,
    PH_P2 = 2'd3
  } phase_e;

  localparam int unsigned        XPT_W            = 4;
  localparam logic [XPT_W-1:0]   XPT_MAX_DEF      = 4'd15;
  localparam logic [7:0]         ITABLE_RESET_DEF = 8'h00;

endpackage

// File: rtl/instruction_phase_sequencer_if.sv
// instruction_phase_sequencer_if
//   Bundle between the sequencer, the memory data bus and the decoders.
//   master : sequencer side (takes bus data and decoder strobes, drives
//            timing state)
//   slave  : decoder / bus side (the mirror image)
interface instruction_phase_sequencer_if;
  import instruction_phase_sequencer_pkg::*;

  logic [7:0]       BUS_DATA;
  logic             Mem_Wait;
  logic             PR_Reset_XPT;
  logic             P2_Set_CM1;
  logic             P2_Reset_ITABLE;
  logic             Pa_Ophd;

  logic [XPT_W-1:0] XPT;
  logic [XPT_W-1:0] notXPT;
  logic [7:0]       ITABLE;
  logic [7:0]       notITABLE;
  logic             OP7;
  logic             notOP7;
  logic             CM1;
  logic             enable;
  logic             Ph_PA;
  logic             Ph_Pa;
  logic             Ph_PR;
  logic             Ph_P2;
  logic             XPT_Overrun;

  modport master (
    input  BUS_DATA, Mem_Wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd,
    output XPT, notXPT, ITABLE, notITABLE, OP7, notOP7, CM1, enable,
           Ph_PA, Ph_Pa, Ph_PR, Ph_P2, XPT_Overrun
  );

  modport slave (
    output BUS_DATA, Mem_Wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd,
    input  XPT, notXPT, ITABLE, notITABLE, OP7, notOP7, CM1, enable,
           Ph_PA, Ph_Pa, Ph_PR, Ph_P2, XPT_Overrun
  );
endinterface

// File: rtl/instruction_phase_sequencer_phase_subcycle_counter.sv
// phase_subcycle_counter
//   Four-state sub-phase counter PA -> Pa -> PR -> P2 -> PA, one clock
//   per sub-phase, holding in PA while mem_wait is high.
//   Ports: clk, rst_n (async, active-low), mem_wait,
//          phase (encoded), ph_onehot (indexed by phase_e).
//
//   state | meaning
//   PH_PA | address phase; stalls here while memory is not ready
//   PH_Pa | operand sample phase
//   PH_PR | end-of-instruction strobe sample phase
//   PH_P2 | step commit phase (XPT / ITABLE / CM1 updates)
module phase_subcycle_counter
  import instruction_phase_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_wait,
  output phase_e     phase,
  output logic [3:0] ph_onehot
);

  phase_e phase_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_PA;
    else        phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    case (phase)
      PH_PA:   phase_next = mem_wait ? PH_PA : PH_Pa;
      PH_Pa:   phase_next = PH_PR;
      PH_PR:   phase_next = PH_P2;
      default: phase_next = PH_PA;
    endcase
  end

  always_comb begin
    ph_onehot        = '0;
    ph_onehot[phase] = 1'b1;
  end

endmodule

// File: rtl/instruction_phase_sequencer.sv
// instruction_phase_sequencer
//   Produces the instruction timing state for the JR/DJNZ-class decoders
//   and applies their step-terminating strobes.
//   Ports: CLK, notRESET (async, active-low),
//          bus (master modport): BUS_DATA, Mem_Wait, decoder strobes in;
//          XPT, ITABLE, OP7 (+ complements), CM1, enable, one-hot
//          sub-phase and sticky XPT_Overrun out.
module instruction_phase_sequencer
  import instruction_phase_sequencer_pkg::*;
#(
  parameter logic [XPT_W-1:0] XPT_MAX      = XPT_MAX_DEF,
  parameter logic [7:0]       ITABLE_RESET = ITABLE_RESET_DEF
) (
  input  logic                          CLK,
  input  logic                          notRESET,
  instruction_phase_sequencer_if.master bus
);

  phase_e           phase;
  logic [3:0]       ph_onehot;
  logic [XPT_W-1:0] xpt;
  logic [7:0]       itable;
  logic             op7;
  logic             cm1;
  logic             rst_pend;
  logic             xpt_overrun;

  phase_subcycle_counter u_phase (
    .clk       (CLK),
    .rst_n     (notRESET),
    .mem_wait  (bus.Mem_Wait),
    .phase     (phase),
    .ph_onehot (ph_onehot)
  );

  // Only bit 7 of the operand register is consumed downstream, so only
  // that bit is kept.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      xpt         <= '0;
      itable      <= ITABLE_RESET;
      op7         <= 1'b0;
      cm1         <= 1'b1;
      rst_pend    <= 1'b0;
      xpt_overrun <= 1'b0;
    end else if (cm1) begin
      // Fetch: decoder strobes are meaningless here and are ignored.
      if (phase == PH_P2) begin
        itable <= bus.BUS_DATA;
        xpt    <= '0;
        cm1    <= 1'b0;
      end
    end else begin
      case (phase)
        PH_Pa: if (!bus.Pa_Ophd) op7 <= bus.BUS_DATA[7];
        PH_PR: if (bus.PR_Reset_XPT) rst_pend <= 1'b1;
        PH_P2: begin
          rst_pend <= 1'b0;
          if (rst_pend)           xpt         <= '0;
          else if (xpt == XPT_MAX) xpt_overrun <= 1'b1;
          else                     xpt         <= xpt + XPT_W'(1);
          if (bus.P2_Set_CM1)      cm1         <= 1'b1;
          if (bus.P2_Reset_ITABLE) itable      <= ITABLE_RESET;
        end
        default: ;
      endcase
    end
  end

  // Complements are derived from the same flops, so they can never
  // disagree with the true outputs.
  assign bus.XPT         = xpt;
  assign bus.notXPT      = ~xpt;
  assign bus.ITABLE      = itable;
  assign bus.notITABLE   = ~itable;
  assign bus.OP7         = op7;
  assign bus.notOP7      = ~op7;
  assign bus.CM1         = cm1;
  assign bus.enable      = ~cm1;
  assign bus.XPT_Overrun = xpt_overrun;
  assign bus.Ph_PA       = ph_onehot[PH_PA];
  assign bus.Ph_Pa       = ph_onehot[PH_Pa];
  assign bus.Ph_PR       = ph_onehot[PH_PR];
  assign bus.Ph_P2       = ph_onehot[PH_P2];

endmodule

// File: tb/tb_instruction_phase_sequencer.sv
module tb_instruction_phase_sequencer;

  typedef struct {
    string      tag;
    logic [3:0] xpt;
    logic [7:0] itable;
    logic       op7;
    logic       cm1;
    logic       ovr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];
  logic [3:0] last_xpt;

  instruction_phase_sequencer_if bus ();

  instruction_phase_sequencer #(
    .XPT_MAX      (4'd15),
    .ITABLE_RESET (8'h00)
  ) dut (
    .CLK      (clk),
    .notRESET (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_ph(input string tag, input logic [3:0] expv);
    chk({tag, "/phase"}, {28'd0, bus.Ph_PA, bus.Ph_Pa, bus.Ph_PR, bus.Ph_P2}, {28'd0, expv});
  endtask

  task automatic push(input string tag, input logic [3:0] xpt, input logic [7:0] itable,
                      input logic op7, input logic cm1, input logic ovr);
    exp_t e;
    e.tag = tag; e.xpt = xpt; e.itable = itable; e.op7 = op7; e.cm1 = cm1; e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    logic [3:0] nx;
    logic [7:0] ni;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e  = exp_q.pop_front();
    nx = ~e.xpt;
    ni = ~e.itable;
    chk({e.tag, "/XPT"},         {28'd0, bus.XPT},         {28'd0, e.xpt});
    chk({e.tag, "/notXPT"},      {28'd0, bus.notXPT},      {28'd0, nx});
    chk({e.tag, "/ITABLE"},      {24'd0, bus.ITABLE},      {24'd0, e.itable});
    chk({e.tag, "/notITABLE"},   {24'd0, bus.notITABLE},   {24'd0, ni});
    chk({e.tag, "/OP7"},         {31'd0, bus.OP7},         {31'd0, e.op7});
    chk({e.tag, "/notOP7"},      {31'd0, bus.notOP7},      {31'd0, ~e.op7});
    chk({e.tag, "/CM1"},         {31'd0, bus.CM1},         {31'd0, e.cm1});
    chk({e.tag, "/enable"},      {31'd0, bus.enable},      {31'd0, ~e.cm1});
    chk({e.tag, "/XPT_Overrun"}, {31'd0, bus.XPT_Overrun}, {31'd0, e.ovr});
    chk_ph(e.tag, 4'b1000);
    last_xpt = e.xpt;
  endtask

  // One machine step. Entered and left at a falling edge while in PA.
  task automatic step(input string tag, input logic [7:0] pa_byte, input logic [7:0] op_byte,
                      input logic [7:0] p2_byte, input int waits, input bit ophd,
                      input bit pr_in_pa, input bit pr_rst, input bit set_cm1, input bit rst_it);
    chk_ph({tag, "/PA"}, 4'b1000);
    bus.BUS_DATA = pa_byte;
    bus.Mem_Wait = (waits > 0);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk_ph({tag, "/wait"}, 4'b1000);
      if (w == waits - 1) bus.Mem_Wait = 1'b0;
    end
    @(negedge clk);
    chk_ph({tag, "/Pa"}, 4'b0100);
    bus.BUS_DATA     = op_byte;
    bus.Pa_Ophd      = ophd;
    bus.PR_Reset_XPT = pr_in_pa;
    @(negedge clk);
    chk_ph({tag, "/PR"}, 4'b0010);
    bus.Pa_Ophd      = 1'b0;
    bus.PR_Reset_XPT = pr_rst;
    @(negedge clk);
    chk_ph({tag, "/P2"}, 4'b0001);
    chk({tag, "/XPT_stable"}, {28'd0, bus.XPT}, {28'd0, last_xpt});
    bus.PR_Reset_XPT    = 1'b0;
    bus.BUS_DATA        = p2_byte;
    bus.P2_Set_CM1      = set_cm1;
    bus.P2_Reset_ITABLE = rst_it;
    @(negedge clk);
    bus.P2_Set_CM1      = 1'b0;
    bus.P2_Reset_ITABLE = 1'b0;
    check_next();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_xpt = 4'd0;
    rst_n = 1'b0;
    bus.BUS_DATA = 8'h00; bus.Mem_Wait = 1'b0; bus.PR_Reset_XPT = 1'b0;
    bus.P2_Set_CM1 = 1'b0; bus.P2_Reset_ITABLE = 1'b0; bus.Pa_Ophd = 1'b0;

    #12;
    push("reset", 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_next();
    @(negedge clk);
    rst_n = 1'b1;
    chk("release/CM1", {31'd0, bus.CM1}, 32'd1);
    chk_ph("release", 4'b1000);

    // fetch of JR opcode
    push("fetch18", 4'd0, 8'h18, 1'b0, 1'b0, 1'b0);
    step("fetch18", 8'h00, 8'h00, 8'h18, 0, 0, 0, 0, 0, 0);

    // JR execute: XPT 0..4 then back to fetch
    push("jr1", 4'd1, 8'h18, 1'b0, 1'b0, 1'b0);
    step("jr1", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    push("jr2", 4'd2, 8'h18, 1'b1, 1'b0, 1'b0);
    step("jr2", 8'h00, 8'hFE, 8'h00, 0, 0, 0, 0, 0, 0);
    push("jr3_hold", 4'd3, 8'h18, 1'b1, 1'b0, 1'b0);
    step("jr3_hold", 8'h00, 8'h05, 8'h00, 0, 1, 0, 0, 0, 0);
    push("jr4", 4'd4, 8'h18, 1'b1, 1'b0, 1'b0);
    step("jr4", 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0, 0);
    push("jr5_end", 4'd0, 8'h18, 1'b1, 1'b1, 1'b0);
    step("jr5_end", 8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 1, 0);

    // stalled fetch with all strobes asserted (ignored in fetch)
    push("fetch_wait", 4'd0, 8'h10, 1'b1, 1'b0, 1'b0);
    step("fetch_wait", 8'h55, 8'h00, 8'h10, 3, 1, 1, 1, 1, 1);

    push("x1", 4'd1, 8'h10, 1'b1, 1'b0, 1'b0);
    step("x1", 8'h00, 8'h80, 8'h00, 0, 0, 0, 0, 0, 0);
    push("x2_misplaced", 4'd2, 8'h10, 1'b0, 1'b0, 1'b0);
    step("x2_misplaced", 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0);
    push("x3_all_strobes", 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    step("x3_all_strobes", 8'h00, 8'h80, 8'h00, 0, 1, 0, 1, 1, 1);

    // overrun
    push("fetch3c", 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("fetch3c", 8'h00, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      push($sformatf("ovr%0d", i), (i < 15) ? 4'(i + 1) : 4'd15, 8'h3C,
           (i % 2 == 1), 1'b0, (i == 15));
      step($sformatf("ovr%0d", i), 8'h00, (i % 2 == 1) ? 8'h80 : 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    end
    push("ovr_hold", 4'd15, 8'h3C, 1'b0, 1'b0, 1'b1);
    step("ovr_hold", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    push("ovr_sticky", 4'd0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step("ovr_sticky", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0);
    push("ovr_count", 4'd1, 8'h3C, 1'b0, 1'b0, 1'b1);
    step("ovr_count", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    // reset mid-step, during PR
    @(negedge clk);
    bus.BUS_DATA = 8'h80;
    @(negedge clk);
    chk_ph("mid/PR", 4'b0010);
    chk("mid/OP7", {31'd0, bus.OP7}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    push("mid_reset", 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_next();
    @(negedge clk);
    rst_n = 1'b1;
    bus.BUS_DATA = 8'h00;
    chk("rerelease/CM1", {31'd0, bus.CM1}, 32'd1);
    chk_ph("rerelease", 4'b1000);
    push("fetch_after_reset", 4'd0, 8'h18, 1'b0, 1'b0, 1'b0);
    step("fetch_after_reset", 8'h00, 8'h00, 8'h18, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
